// File: rtl/sha1_msg_padder_if.sv
// Handshake bundle between a message producer and the SHA-1 padder.
// The master side feeds message words and consumes padded blocks; the
// slave side is the padder itself.
interface sha1_msg_padder_if;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_bytes, in_last, in_valid, out_ready,
    input  in_ready, out_block, out_first, out_last, out_valid
  );

  modport slave (
    input  in_data, in_bytes, in_last, in_valid, out_ready,
    output in_ready, out_block, out_first, out_last, out_valid
  );
endinterface

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: collects 32-bit message words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit big-endian bit length,
// and flags the first and last block of each message.
// Optional feature macro: SHA1_PAD_BYTESWAP_EN (byte-reverse in_data on entry,
// so the first message byte arrives in [7:0]).
module sha1_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sha1_msg_padder_if.slave     padIf
);

  typedef enum logic [1:0] {LOAD, PAD, LEN, EMIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0][31:0]  blk_q, blk_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               pad_q, pad_d;
  logic               mark_q, mark_d;
  logic               armed_q;

  logic [31:0]        inWord;
  logic [31:0]        loadWord;
  logic [31:0]        wordVal;
  logic               wrWord;
  logic               accept;
  logic [63:0]        len64;

  assign padIf.in_ready  = armed_q && (state_q == LOAD);
  assign padIf.out_valid = (state_q == EMIT);
  assign padIf.out_block = blk_q;
  assign padIf.out_first = first_q;
  assign padIf.out_last  = last_q;

  assign accept = padIf.in_valid && padIf.in_ready;
  assign len64  = 64'(len_q);

  // Normalise the incoming word, clear bytes past in_bytes and drop in the marker on a short last word
  always_comb begin
`ifdef SHA1_PAD_BYTESWAP_EN
    inWord = {padIf.in_data[7:0], padIf.in_data[15:8],
              padIf.in_data[23:16], padIf.in_data[31:24]};
`else
    inWord = padIf.in_data;
`endif
    loadWord = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < padIf.in_bytes) begin
        loadWord[31-8*k -: 8] = inWord[31-8*k -: 8];
      end else if (padIf.in_last && (3'(k) == padIf.in_bytes)) begin
        loadWord[31-8*k -: 8] = 8'h80;
      end
    end
  end

  // Next-state logic: word writes, length accumulation, block sequencing
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    len_d   = len_q;
    blk_d   = blk_q;
    first_d = first_q;
    last_d  = last_q;
    pad_d   = pad_q;
    mark_d  = mark_q;
    wordVal = '0;
    wrWord  = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          wordVal = loadWord;
          wrWord  = 1'b1;
          len_d   = len_q + LEN_W'({padIf.in_bytes, 3'b000});
          if (padIf.in_last) begin
            pad_d = 1'b1;
            if (padIf.in_bytes < 3'd4) mark_d = 1'b1;
          end
        end
      end
      PAD: begin
        wordVal = mark_q ? 32'h0000_0000 : 32'h8000_0000;
        wrWord  = 1'b1;
        mark_d  = 1'b1;
      end
      LEN: begin
        blk_d[1] = len64[63:32];
        blk_d[0] = len64[31:0];
        last_d   = 1'b1;
        state_d  = EMIT;
      end
      EMIT: begin
        if (padIf.out_ready) begin
          widx_d  = 4'd0;
          first_d = 1'b0;
          if (last_q) begin
            len_d   = '0;
            first_d = 1'b1;
            last_d  = 1'b0;
            pad_d   = 1'b0;
            mark_d  = 1'b0;
            state_d = LOAD;
          end else if (pad_q) begin
            state_d = PAD;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (wrWord) begin
      blk_d[4'd15 - widx_q] = wordVal;
      if (!pad_d) begin
        if (widx_q == 4'd15) begin
          state_d = EMIT;
        end else begin
          state_d = LOAD;
          widx_d  = widx_q + 4'd1;
        end
      end else if (mark_d) begin
        if (widx_q == 4'd13) begin
          state_d = LEN;
        end else if (widx_q == 4'd15) begin
          state_d = EMIT;
        end else begin
          state_d = PAD;
          widx_d  = widx_q + 4'd1;
        end
      end else begin
        if (widx_q == 4'd15) begin
          state_d = EMIT;
        end else begin
          state_d = PAD;
          widx_d  = widx_q + 4'd1;
        end
      end
    end
  end

  // State registers; in_ready is held off until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      widx_q  <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      mark_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      first_q <= first_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      mark_q  <= mark_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: directed messages with hand-computed
// padded blocks pushed into a scoreboard queue and checked by a monitor.
module tb_sha1_msg_padder;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  sha1_msg_padder_if bus ();

  sha1_msg_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .padIf (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and log any failure
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-reverse stimulus when the design expects the first byte in [7:0]
  function automatic logic [31:0] toDut(input logic [31:0] d);
`ifdef SHA1_PAD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Offer one message word and hold it until the padder takes it
  task automatic applyStimulus(input logic [31:0] d, input logic [2:0] nb, input logic lst);
    int waitCycles = 0;
    bus.in_data  = toDut(d);
    bus.in_bytes = nb;
    bus.in_last  = lst;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      waitCycles++;
    end while (!bus.in_ready && waitCycles < 100);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pushExp(input logic [15:0][31:0] b, input logic f, input logic l);
    exp_t e;
    e.blk   = b;
    e.first = f;
    e.last  = l;
    expQ.push_back(e);
  endtask

  // Wait until every expected block has been delivered
  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (expQ.size() != 0 || bus.out_valid) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d pending required=0", expQ.size());
    end
  endtask

  // Scoreboard monitor: every block handshake pops and compares one expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_block actual=%h required=none", bus.out_block);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_block", bus.out_block, e.blk);
        checkOutput("out_first", 512'(bus.out_first), 512'(e.first));
        checkOutput("out_last",  512'(bus.out_last),  512'(e.last));
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    logic [15:0][31:0] b;
    logic [511:0] held;
    int n;

    rst_n        = 1'b0;
    bus.in_data  = '0;
    bus.in_bytes = '0;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    checkOutput("rst_out_valid", 512'(bus.out_valid), 512'(0));
    checkOutput("rst_in_ready",  512'(bus.in_ready),  512'(0));
    checkOutput("rst_out_first", 512'(bus.out_first), 512'(1));
    checkOutput("rst_out_last",  512'(bus.out_last),  512'(0));
    checkOutput("rst_out_block", bus.out_block, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 512'(bus.in_ready), 512'(0));
    @(posedge clk);
    #1;
    checkOutput("armed_in_ready", 512'(bus.in_ready), 512'(1));

    // "abc"
    $display("[TB] abc");
    b = '0; b[15] = 32'h6162_6380; b[0] = 32'h0000_0018;
    pushExp(b, 1'b1, 1'b1);
    applyStimulus(32'h6162_6300, 3'd3, 1'b1);
    waitDrain();

    // Empty message
    $display("[TB] empty");
    b = '0; b[15] = 32'h8000_0000;
    pushExp(b, 1'b1, 1'b1);
    applyStimulus(32'h0000_0000, 3'd0, 1'b1);
    waitDrain();

    // "abcde": marker lands in W1 byte 1
    $display("[TB] abcde");
    b = '0; b[15] = 32'h6162_6364; b[14] = 32'h6580_0000; b[0] = 32'h0000_0028;
    pushExp(b, 1'b1, 1'b1);
    applyStimulus(32'h6162_6364, 3'd4, 1'b0);
    applyStimulus(32'h65AA_BBCC, 3'd1, 1'b1);
    waitDrain();

    // 56 bytes: marker and length no longer fit, spill into a second block
    $display("[TB] 56 bytes");
    b = '0;
    for (int i = 0; i < 14; i++) b[15-i] = 32'hA000_0000 + 32'(i);
    b[1] = 32'h8000_0000;
    pushExp(b, 1'b1, 1'b0);
    b = '0; b[0] = 32'h0000_01C0;
    pushExp(b, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(32'hA000_0000 + 32'(i), 3'd4, (i == 13));
    waitDrain();

    // 64 bytes: full data block, then marker-only block
    $display("[TB] 64 bytes");
    b = '0;
    for (int i = 0; i < 16; i++) b[15-i] = 32'hB100_0000 + 32'(i * 3);
    pushExp(b, 1'b1, 1'b0);
    b = '0; b[15] = 32'h8000_0000; b[0] = 32'h0000_0200;
    pushExp(b, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(32'hB100_0000 + 32'(i * 3), 3'd4, (i == 15));
    waitDrain();

    // Backpressure: block must hold steady and input must stay closed
    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    b = '0; b[15] = 32'h6162_6380; b[0] = 32'h0000_0018;
    pushExp(b, 1'b1, 1'b1);
    applyStimulus(32'h6162_6300, 3'd3, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_out_valid_seen", 512'(bus.out_valid), 512'(1));
    held = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_out_block", bus.out_block, held);
      checkOutput("stall_in_ready", 512'(bus.in_ready), 512'(0));
      checkOutput("stall_out_valid", 512'(bus.out_valid), 512'(1));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitDrain();

    // Back-to-back "abc" messages
    $display("[TB] back-to-back abc");
    pushExp(b, 1'b1, 1'b1);
    pushExp(b, 1'b1, 1'b1);
    applyStimulus(32'h6162_6300, 3'd3, 1'b1);
    applyStimulus(32'h6162_6300, 3'd3, 1'b1);
    waitDrain();

    // Reset mid-message discards everything
    $display("[TB] reset mid-message");
    for (int i = 0; i < 5; i++) applyStimulus(32'hC0C0_C0C0 + 32'(i), 3'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 512'(bus.out_valid), 512'(0));
    checkOutput("midrst_in_ready",  512'(bus.in_ready),  512'(0));
    checkOutput("midrst_out_block", bus.out_block, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pushExp(b, 1'b1, 1'b1);
    applyStimulus(32'h6162_6300, 3'd3, 1'b1);
    waitDrain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
